// File: rtl/fp_to_int_seq.sv
// Iterative float-to-signed-integer converter with C-style truncation toward zero.
// One word in flight; result held under output backpressure until taken.
module fp_to_int_seq #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int INT_WIDTH      = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  FP_in,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [INT_WIDTH-1:0]                    int_out,
  output logic                                    overflow
);

  localparam int EW    = EXPONENT_WIDTH;
  localparam int MW    = MANTISSA_WIDTH;
  localparam int IW    = INT_WIDTH;
  localparam int BIAS  = (1 << (EW-1)) - 1;
  // Left shifts reach at most IW-2-MW; right shifts at most MW.
  localparam int MAXC  = (MW > IW-2-MW) ? MW : IW-2-MW;
  localparam int CNT_W = $clog2(MAXC+1);

  localparam logic [IW-1:0] POS_MAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] NEG_MIN = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     acc;
  logic [CNT_W-1:0]  cnt;
  logic              dir_right;
  logic              sgn;

  // Field decode of the incoming word
  logic              sgn_in;
  logic [EW-1:0]     exp_in;
  logic [MW-1:0]     man_in;
  logic signed [EW:0] e_unb;
  int                e_int;

  assign {sgn_in, exp_in, man_in} = FP_in;
  assign e_unb = $signed({1'b0, exp_in}) - $signed((EW+1)'(BIAS));
  assign e_int = {{(32-EW-1){e_unb[EW]}}, e_unb};

  logic              accept;
  assign accept = in_valid && in_ready;

  // Classification of the word at the input
  logic              spec_hit;
  logic [IW-1:0]     spec_val;
  logic              spec_ovf;
  logic [CNT_W-1:0]  cnt_init;
  logic              right_init;
  logic [IW-1:0]     sig_init;
  int                diff;

  always_comb begin
    spec_hit   = 1'b0;
    spec_val   = '0;
    spec_ovf   = 1'b0;
    diff       = e_int - MW;
    right_init = (diff < 0);
    cnt_init   = CNT_W'((diff < 0) ? -diff : diff);
    sig_init   = {{(IW-MW-1){1'b0}}, 1'b1, man_in};
    if (&exp_in) begin
      spec_hit = 1'b1;
      spec_ovf = 1'b1;
      // NaN always saturates positive; Inf follows its sign
      spec_val = (man_in != '0) ? POS_MAX : (sgn_in ? NEG_MIN : POS_MAX);
    end else if (exp_in == '0) begin
      spec_hit = 1'b1;
    end else if (e_int < 0) begin
      spec_hit = 1'b1;
    end else if (e_int == IW-1 && sgn_in && man_in == '0) begin
      spec_hit = 1'b1;
      spec_val = NEG_MIN;
    end else if (e_int >= IW-1) begin
      spec_hit = 1'b1;
      spec_ovf = 1'b1;
      spec_val = sgn_in ? NEG_MIN : POS_MAX;
    end
  end

  logic [IW-1:0] acc_fin;
  assign acc_fin = sgn ? (~acc + {{(IW-1){1'b0}}, 1'b1}) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      int_out   <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      dir_right <= 1'b0;
      sgn       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready  <= 1'b0;
            sgn       <= sgn_in;
            acc       <= sig_init;
            dir_right <= right_init;
            cnt       <= cnt_init;
            if (spec_hit) begin
              int_out   <= spec_val;
              overflow  <= spec_ovf;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (cnt_init != '0) begin
              state <= SHIFT;
            end else begin
              state <= NEGATE;
            end
          end
        end
        SHIFT: begin
          // Right shifts drop fraction bits, which is exactly truncation
          acc <= dir_right ? (acc >> 1) : (acc << 1);
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= NEGATE;
        end
        NEGATE: begin
          acc       <= acc_fin;
          int_out   <= acc_fin;
          overflow  <= 1'b0;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed bench for fp_to_int_seq: vector table plus backpressure and reset-abort sequences.
module tb_fp_to_int_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] FP_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  fp_to_int_seq #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .INT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .FP_in(FP_in),
    .out_valid(out_valid), .out_ready(out_ready), .int_out(int_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fp;
    logic [31:0] exp_int;
    logic        exp_ovf;
    int          exp_lat;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one word and returns at the first negedge where out_valid is high.
  task automatic convert(input logic [31:0] fp, output logic [31:0] got_int,
                         output logic got_ovf, output int lat, output logic ok);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    in_valid = 1'b1;
    FP_in    = fp;
    @(negedge clk);
    in_valid = 1'b0;
    FP_in    = 32'hDEADBEEF;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    ok      = out_valid;
    got_int = int_out;
    got_ovf = overflow;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gi;
    logic        go;
    logic        ok;
    int          lat;
    logic        seen;

    vecs[0]  = '{32'h40F40000, 32'h00000007, 1'b0, 23};
    vecs[1]  = '{32'hC1200000, 32'hFFFFFFF6, 1'b0, 22};
    vecs[2]  = '{32'h42820000, 32'h00000041, 1'b0, 19};
    vecs[3]  = '{32'h4B000000, 32'h00800000, 1'b0, 2};
    vecs[4]  = '{32'h3F000000, 32'h00000000, 1'b0, 1};
    vecs[5]  = '{32'hBE99999A, 32'h00000000, 1'b0, 1};
    vecs[6]  = '{32'h00000000, 32'h00000000, 1'b0, 1};
    vecs[7]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1};
    vecs[8]  = '{32'hCF000000, 32'h80000000, 1'b0, 1};
    vecs[9]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1};
    vecs[10] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1};
    vecs[11] = '{32'hFF800000, 32'h80000000, 1'b1, 1};
    vecs[12] = '{32'h4EC00000, 32'h60000000, 1'b0, 9};
    vecs[13] = '{32'hCEC00000, 32'hA0000000, 1'b0, 9};
    vecs[14] = '{32'hCF000001, 32'h80000000, 1'b1, 1};
    vecs[15] = '{32'hBF800000, 32'hFFFFFFFF, 1'b0, 25};
    vecs[16] = '{32'h00000001, 32'h00000000, 1'b0, 1};
    vecs[17] = '{32'h3F800000, 32'h00000001, 1'b0, 25};
    vecs[18] = '{32'hFFC00000, 32'h7FFFFFFF, 1'b1, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    FP_in     = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_int_out",   int_out,            32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      convert(vecs[i].fp, gi, go, lat, ok);
      chk($sformatf("v%0d_timeout", i), {31'd0, ok}, 32'd1);
      chk($sformatf("v%0d_int", i), gi, vecs[i].exp_int);
      chk($sformatf("v%0d_ovf", i), {31'd0, go}, {31'd0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_handoff_valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_handoff_ready", i), {31'd0, in_ready},  32'd1);
    end

    // Backpressure: result held, new input ignored
    out_ready = 1'b0;
    convert(32'h42820000, gi, go, lat, ok);
    chk("bp_timeout", {31'd0, ok}, 32'd1);
    chk("bp_int", gi, 32'h00000041);
    in_valid = 1'b1;
    FP_in    = 32'h3F800000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_int", k),   int_out,            32'h00000041);
      chk($sformatf("bp%0d_ovf", k),   {31'd0, overflow},  32'd0);
      chk($sformatf("bp%0d_ready", k), {31'd0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready},  32'd1);
    convert(32'hC1200000, gi, go, lat, ok);
    chk("bp_next_int", gi, 32'hFFFFFFF6);
    chk("bp_next_lat", 32'(lat), 32'd22);
    @(negedge clk);

    // Reset in the middle of a shift sequence
    in_valid = 1'b1;
    FP_in    = 32'h40F40000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_ready", {31'd0, in_ready},  32'd1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", {31'd0, seen}, 32'd0);
    convert(32'hC2100000, gi, go, lat, ok);
    chk("abort_next_timeout", {31'd0, ok}, 32'd1);
    chk("abort_next_int", gi, 32'hFFFFFFDC);
    chk("abort_next_ovf", {31'd0, go}, 32'd0);
    chk("abort_next_lat", 32'(lat), 32'd20);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
